// File: rtl/hazard_ctrl.sv
// Purpose: stall/clear/forward control for the 5-stage MIPS pipeline, plus mult/div busy timer and stall counter.
// Latency: stall, enables and forward selects are combinational; md_busy and stall_cnt are registered (1 cycle).
// Backpressure: stall freezes PC and F/D and bubbles D/E; E/M is never held or cleared.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_A1,
  input  logic [4:0]       D_A2,
  input  logic             D_A1use,
  input  logic             D_A2use,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_A1,
  input  logic [4:0]       E_A2,
  input  logic [4:0]       E_A3,
  input  logic             E_Reg_Write,
  input  logic [3:0]       E_Tnew,
  input  logic [1:0]       E_md_start,
  input  logic [4:0]       M_A2,
  input  logic [4:0]       M_A3,
  input  logic             M_Reg_Write,
  input  logic [3:0]       M_Tnew,
  input  logic [4:0]       W_A3,
  input  logic             W_Reg_Write,
  output logic             stall,
  output logic             PC_WE,
  output logic             F_D_RegWE,
  output logic             D_E_clear,
  output logic             E_M_RegWE,
  output logic             E_M_clear,
  output logic [1:0]       D_fwd_rs,
  output logic [1:0]       D_fwd_rt,
  output logic [1:0]       E_fwd_rs,
  output logic [1:0]       E_fwd_rt,
  output logic             M_fwd_rt,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Counter must hold the longer of the two latencies, never narrower than 4 bits.
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W   = ($clog2(MD_MAX + 1) < 4) ? 4 : $clog2(MD_MAX + 1);

  logic [MD_W-1:0] md_cnt;

  logic e_hit_d1, m_hit_d1, w_hit_d1;
  logic e_hit_d2, m_hit_d2, w_hit_d2;
  logic m_hit_e1, w_hit_e1, m_hit_e2, w_hit_e2;
  logic w_hit_m2;
  logic stall_rs, stall_rt, stall_md;
  logic md_start_mult, md_start_div;

  // Producer/consumer register matches; $0 never matches anything.
  always_comb begin
    e_hit_d1 = E_Reg_Write && (E_A3 == D_A1) && (D_A1 != 5'd0);
    m_hit_d1 = M_Reg_Write && (M_A3 == D_A1) && (D_A1 != 5'd0);
    w_hit_d1 = W_Reg_Write && (W_A3 == D_A1) && (D_A1 != 5'd0);
    e_hit_d2 = E_Reg_Write && (E_A3 == D_A2) && (D_A2 != 5'd0);
    m_hit_d2 = M_Reg_Write && (M_A3 == D_A2) && (D_A2 != 5'd0);
    w_hit_d2 = W_Reg_Write && (W_A3 == D_A2) && (D_A2 != 5'd0);
    m_hit_e1 = M_Reg_Write && (M_A3 == E_A1) && (E_A1 != 5'd0);
    w_hit_e1 = W_Reg_Write && (W_A3 == E_A1) && (E_A1 != 5'd0);
    m_hit_e2 = M_Reg_Write && (M_A3 == E_A2) && (E_A2 != 5'd0);
    w_hit_e2 = W_Reg_Write && (W_A3 == E_A2) && (E_A2 != 5'd0);
    w_hit_m2 = W_Reg_Write && (W_A3 == M_A2) && (M_A2 != 5'd0);
  end

  // Stall when a producer's result arrives later than the D instruction needs it,
  // or when a mult/div-family instruction meets a busy or just-starting unit.
  always_comb begin
    md_start_mult = (E_md_start == 2'b01);
    md_start_div  = (E_md_start == 2'b10);
    stall_rs = D_A1use && ((e_hit_d1 && (E_Tnew > {2'b00, D_Tuse_rs})) ||
                           (m_hit_d1 && (M_Tnew > {2'b00, D_Tuse_rs})));
    stall_rt = D_A2use && ((e_hit_d2 && (E_Tnew > {2'b00, D_Tuse_rt})) ||
                           (m_hit_d2 && (M_Tnew > {2'b00, D_Tuse_rt})));
    stall_md = D_is_md && (md_busy || md_start_mult || md_start_div);
    stall    = stall_rs || stall_rt || stall_md;
    PC_WE     = ~stall;
    F_D_RegWE = ~stall;
    D_E_clear = stall;
    E_M_RegWE = 1'b1;
    E_M_clear = 1'b0;
  end

  // Forward selects: youngest ready producer wins.
  always_comb begin
    D_fwd_rs = 2'd0;
    D_fwd_rt = 2'd0;
    E_fwd_rs = 2'd0;
    E_fwd_rt = 2'd0;
    M_fwd_rt = 1'b0;
    if (e_hit_d1 && (E_Tnew == 4'd0))      D_fwd_rs = 2'd3;
    else if (m_hit_d1 && (M_Tnew == 4'd0)) D_fwd_rs = 2'd2;
    else if (w_hit_d1)                     D_fwd_rs = 2'd1;
    if (e_hit_d2 && (E_Tnew == 4'd0))      D_fwd_rt = 2'd3;
    else if (m_hit_d2 && (M_Tnew == 4'd0)) D_fwd_rt = 2'd2;
    else if (w_hit_d2)                     D_fwd_rt = 2'd1;
    if (m_hit_e1 && (M_Tnew == 4'd0))      E_fwd_rs = 2'd2;
    else if (w_hit_e1)                     E_fwd_rs = 2'd1;
    if (m_hit_e2 && (M_Tnew == 4'd0))      E_fwd_rt = 2'd2;
    else if (w_hit_e2)                     E_fwd_rt = 2'd1;
    if (w_hit_m2)                          M_fwd_rt = 1'b1;
  end

  // Mult/div busy timer: loads on a start while idle, then counts down to zero.
  // Starts seen while already counting are ignored; the stall keeps them from happening.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_cnt == '0) begin
      if (md_start_mult)     md_cnt <= MD_W'(MULT_CYCLES);
      else if (md_start_div) md_cnt <= MD_W'(DIV_CYCLES);
    end else begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
